// File: rtl/exception_sequencer_pkg.sv
// Shared types for the exception sequencer: FSM states, cause codes and
// memory-address mux select encodings.
package exception_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SAVE = 2'b01,
    REQ  = 2'b10,
    LOAD = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } cause_t;

  localparam logic [2:0] IORD_PC     = 3'b000;
  localparam logic [2:0] IORD_ALUOUT = 3'b001;
  localparam logic [2:0] IORD_VEC253 = 3'b010;
  localparam logic [2:0] IORD_VEC254 = 3'b011;
  localparam logic [2:0] IORD_VEC255 = 3'b100;
  localparam logic [2:0] IORD_AUX    = 3'b101;

  // Each cause fetches its handler address from a dedicated vector byte.
  function automatic logic [2:0] iord_vec(input cause_t c);
    case (c)
      CAUSE_OPCODE: iord_vec = IORD_VEC253;
      CAUSE_OVF:    iord_vec = IORD_VEC254;
      CAUSE_DIV0:   iord_vec = IORD_VEC255;
      default:      iord_vec = IORD_PC;
    endcase
  endfunction

endpackage

// File: rtl/exception_sequencer_prio_enc.sv
// Fixed-priority encoder: opcode > overflow > div0, 00 when none pending.
module exc_prio_enc
  import exception_sequencer_pkg::*;
(
  input  logic   opcode_i,
  input  logic   overflow_i,
  input  logic   div0_i,
  output cause_t cause_o
);

  always_comb begin
    cause_o = CAUSE_NONE;
    if (opcode_i)        cause_o = CAUSE_OPCODE;
    else if (overflow_i) cause_o = CAUSE_OVF;
    else if (div0_i)     cause_o = CAUSE_DIV0;
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer: saves EPC, reads the vector byte from memory
// and loads it into the PC, with a bounded wait and sticky error flags.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic        mem_ready,
  input  logic [7:0]  mem_byte,
  input  logic        err_clr,
  output logic [2:0]  iord_sel,
  output logic        mem_rd,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  localparam logic [4:0] TIMEOUT_CNT = 5'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  cause_t      cause_q, cause_d, enc_cause;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  byte_q, byte_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        tout_q, tout_d;
  logic        ovr_q, ovr_d;
  logic        any_exc;

  exc_prio_enc u_prio (
    .opcode_i   (exc_opcode),
    .overflow_i (exc_overflow),
    .div0_i     (exc_div0),
    .cause_o    (enc_cause)
  );

  assign any_exc = exc_opcode | exc_overflow | exc_div0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      epc_q   <= 32'h0;
      byte_q  <= 8'h0;
      cnt_q   <= 5'd0;
      tout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      ovr_q   <= ovr_d;
    end
  end

  // Memory handshake: mem_rd is held for the whole REQ state; the read
  // completes on the first rising edge at which mem_ready is sampled high.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    ovr_d   = ovr_q;
    if (err_clr) begin
      tout_d = 1'b0;
      ovr_d  = 1'b0;
    end
    // Set events are applied after the clear so they win a same-cycle tie.
    if (state_q != IDLE && any_exc) ovr_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (any_exc) begin
          state_d = SAVE;
          cause_d = enc_cause;
          epc_d   = pc_in - 32'd4;
        end
      end
      SAVE: begin
        state_d = REQ;
        cnt_d   = 5'd0;
      end
      REQ: begin
        if (mem_ready) begin
          byte_d  = mem_byte;
          state_d = LOAD;
        end else if (cnt_q == TIMEOUT_CNT) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign iord_sel    = (state_q == REQ || state_q == LOAD) ? iord_vec(cause_q) : IORD_PC;
  assign mem_rd      = (state_q == REQ);
  assign epc_wr      = (state_q == SAVE);
  assign pc_wr       = (state_q == LOAD);
  assign done        = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign epc_data    = epc_q;
  assign pc_data     = {24'h0, byte_q};
  assign cause       = cause_q;
  assign timeout_err = tout_q;
  assign overrun     = ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Randomized scoreboard bench for exception_sequencer: the driver pushes the
// expected completion event of each sequence, a negedge monitor pops/compares.
module tb_exception_sequencer;

  localparam int W = 86;  // {is_timeout, cause, iord, epc, pc_field, cycle}

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in;
  logic        mem_ready;
  logic [7:0]  mem_byte;
  logic        err_clr;
  logic [2:0]  iord_sel;
  logic        mem_rd, epc_wr, pc_wr, busy, done, timeout_err, overrun;
  logic [31:0] epc_data, pc_data;
  logic [1:0]  cause, dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  bit tout_exp, ovr_exp;
  logic [2:0] vec_tbl [4];

  exception_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_ready(mem_ready), .mem_byte(mem_byte), .err_clr(err_clr),
    .iord_sel(iord_sel), .mem_rd(mem_rd), .epc_wr(epc_wr), .epc_data(epc_data),
    .pc_wr(pc_wr), .pc_data(pc_data), .cause(cause), .busy(busy), .done(done),
    .timeout_err(timeout_err), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic prev_tout = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    if (pc_wr || (timeout_err && !prev_tout)) begin
      act = {timeout_err && !prev_tout, cause, iord_sel, epc_data,
             pc_wr ? pc_data : 32'h0, 16'(cyc)};
      if (exp_q.size() == 0) begin
        chk("unexpected_event", act, '0);
      end else begin
        exp = exp_q.pop_front();
        chk(pc_wr ? "pc_wr_event" : "timeout_event", act, exp);
      end
      if (pc_wr) chk("done_with_pc_wr", {84'h0, done, epc_wr}, {84'h0, 1'b1, 1'b0});
    end
    prev_tout <= timeout_err;
  end

  // ---------------- driver ----------------
  // exc: {opcode, overflow, div0}; d: REQ cycles with mem_ready low before
  // it rises (>= 16 means it never does); poke: 1 = div0 during REQ,
  // 2 = div0 together with err_clr during REQ.
  task automatic do_seq(input logic [2:0] exc, input logic [31:0] pc, input int d,
                        input logic [7:0] b, input int poke);
    int c;
    int exp_cause;
    c = cyc;
    if (exc[2]) exp_cause = 1;
    else if (exc[1]) exp_cause = 2;
    else exp_cause = 3;
    if (d >= 16)
      exp_q.push_back({1'b1, 2'(exp_cause), 3'b000, pc - 32'd4, 32'h0, 16'(c + 18)});
    else
      exp_q.push_back({1'b0, 2'(exp_cause), vec_tbl[exp_cause], pc - 32'd4,
                       {24'h0, b}, 16'(c + 3 + d)});
    {exc_opcode, exc_overflow, exc_div0} = exc;
    pc_in = pc;
    tick();
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    pc_in = $urandom;
    tick();
    for (int i = 0; i < 16 && i <= d; i++) begin
      mem_ready = (i == d);
      mem_byte  = (i == d) ? b : 8'($urandom);
      exc_div0  = (poke != 0 && i == 0);
      err_clr   = (poke == 2 && i == 0);
      tick();
      mem_ready = 1'b0;
      exc_div0  = 1'b0;
      err_clr   = 1'b0;
    end
    if (d < 16) tick();
    if (poke != 0) ovr_exp = 1'b1;
    if (d >= 16) tout_exp = 1'b1;
    chk("idle_after_seq", {80'h0, busy, mem_rd, iord_sel, cause == 2'(exp_cause)},
        {80'h0, 1'b0, 1'b0, 3'b000, 1'b1});
    chk("flags_after_seq", {84'h0, timeout_err, overrun}, {84'h0, tout_exp, ovr_exp});
    if (tout_exp || ovr_exp) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tout_exp = 1'b0;
      ovr_exp = 1'b0;
      chk("flags_cleared", {84'h0, timeout_err, overrun}, 86'h0);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {11'h0, iord_sel, mem_rd, epc_wr, pc_wr, done, busy, timeout_err, overrun,
               cause, epc_data, pc_data},
        '0);
  endtask

  initial begin
    vec_tbl[0] = 3'b000; vec_tbl[1] = 3'b010; vec_tbl[2] = 3'b011; vec_tbl[3] = 3'b100;
    reset_n = 1'b0;
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    pc_in = 32'h0; mem_ready = 1'b0; mem_byte = 8'h0; err_clr = 1'b0;
    tout_exp = 1'b0; ovr_exp = 1'b0;
    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    chk_all_zero("idle_no_request");

    // directed cases
    do_seq(3'b010, 32'h0000_0040, 0, 8'h80, 0);   // overflow, EPC 0x3C, vector 254
    do_seq(3'b111, 32'h1000_0008, 2, 8'h5A, 0);   // all three -> opcode wins
    do_seq(3'b001, 32'h0000_1234, 20, 8'h00, 0);  // timeout after 16 REQ cycles
    do_seq(3'b100, 32'h0000_0100, 1, 8'h11, 1);   // div0 while busy -> overrun
    do_seq(3'b001, 32'h0000_0200, 0, 8'h22, 2);   // set wins over err_clr
    do_seq(3'b100, 32'h0000_0000, 15, 8'hFF, 0);  // EPC wraps; ready on last REQ cycle

    // reset in the middle of REQ aborts the sequence
    exc_opcode = 1'b1;
    pc_in = 32'hABCD_0010;
    tick();
    exc_opcode = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_req");
    tick();
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_all_zero("idle_after_reset");

    // randomized sequences
    for (int n = 0; n < 24; n++) begin
      logic [2:0] e;
      int d;
      e = 3'($urandom_range(1, 7));
      d = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
      do_seq(e, $urandom, d, 8'($urandom), $urandom_range(0, 4) == 0 ? 1 : 0);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    tick();
    tick();
    chk("queue_drained", 86'(exp_q.size()), 86'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
